// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 hex keypad entry path.
//   state_t      - scan FSM states (SCAN, DEBOUNCE, HELD)
//   ROW_RESET    - row drive after reset (row 0 driven low)
//   KEY_MAP      - 16 nibbles indexed by {row, col}
//   key_lookup   - hex code of the key at (row, col)
//   row_index    - row number from the active-low one-hot row drive
//   decode_cols  - {hit, col} for a single low column, hit=0 otherwise
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0] ROW_RESET = 4'b1110;

  // Nibble {row,col} holds the legend of that key:
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [5:0] base;
    base = {r, c, 2'b00};
    return KEY_MAP[base +: 4];
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Exactly one low column is a hit; none or several low columns are "no key".
  function automatic logic [2:0] decode_cols(input logic [3:0] cols);
    logic [2:0] res;
    case (cols)
      4'b1110: res = 3'b100;
      4'b1101: res = 3'b101;
      4'b1011: res = 3'b110;
      4'b0111: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_entry_scan_tick.sv
// scan_tick: free-running divider emitting a one-cycle tick every DIVIDE
// clocks. The first tick appears DIVIDE cycles after reset is released.
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   tick - single-cycle pulse
module scan_tick #(
  parameter int DIVIDE = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 active-low hex keypad, debounces presses and
// releases, and shifts each accepted digit into a 16-bit value.
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   col_in     - keypad columns, active-low, asynchronous to clk
//   clear      - synchronous pulse, zeroes value
//   row_select - keypad rows, active-low, exactly one low
//   value      - entered digits, newest in [3:0]
//   key_code   - code of the last accepted key
//   key_valid  - one-cycle pulse per accepted key
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int CLOCK_SPEED    = 100000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_in,
  input  logic        clear,
  output logic [3:0]  row_select,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int TP    = CLOCK_SPEED / SCAN_HZ;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [3:0]       col_p0;
  logic [3:0]       col_p1;
  logic             tick;
  state_t           state;
  logic [1:0]       lat_row;
  logic [1:0]       lat_col;
  logic [CNT_W-1:0] db_cnt;

  logic [2:0] hit_info;
  logic       hit;
  logic [1:0] hit_col;
  logic       same_hit;
  logic       accept;
  logic [3:0] accept_code;

  scan_tick #(.DIVIDE(TP)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Stage p0/p1: two-flop synchroniser; idle level is all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_p0 <= 4'hF;
      col_p1 <= 4'hF;
    end else begin
      col_p0 <= col_in;
      col_p1 <= col_p0;
    end
  end

  always_comb begin
    hit_info    = decode_cols(col_p1);
    hit         = hit_info[2];
    hit_col     = hit_info[1:0];
    same_hit    = hit && (hit_col == lat_col);
    accept      = tick && (state == DEBOUNCE) && same_hit && (db_cnt == DB_LAST);
    accept_code = key_lookup(lat_row, lat_col);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SCAN;
      row_select <= ROW_RESET;
      lat_row    <= 2'd0;
      lat_col    <= 2'd0;
      db_cnt     <= '0;
      value      <= 16'h0000;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
    end else begin
      key_valid <= 1'b0;

      // A clear that lands with a new key keeps only that key; a clear in the
      // key_valid cycle likewise keeps the digit that was just entered.
      if (accept) begin
        value <= clear ? {12'h000, accept_code} : {value[11:0], accept_code};
      end else if (clear) begin
        value <= key_valid ? {12'h000, key_code} : 16'h0000;
      end

      if (tick) begin
        case (state)
          SCAN: begin
            if (hit) begin
              lat_row <= row_index(row_select);
              lat_col <= hit_col;
              db_cnt  <= CNT_W'(1);
              state   <= DEBOUNCE;
            end else begin
              row_select <= {row_select[2:0], row_select[3]};
            end
          end
          DEBOUNCE: begin
            if (accept) begin
              key_valid <= 1'b1;
              key_code  <= accept_code;
              db_cnt    <= '0;
              state     <= HELD;
            end else if (same_hit) begin
              db_cnt <= db_cnt + CNT_W'(1);
            end else begin
              db_cnt     <= '0;
              state      <= SCAN;
              row_select <= {row_select[2:0], row_select[3]};
            end
          end
          HELD: begin
            // Only a fully released row counts; anything else restarts the count,
            // so a second key pressed here is ignored until full release.
            if (col_p1 == 4'hF) begin
              if (db_cnt == DB_LAST) begin
                db_cnt     <= '0;
                state      <= SCAN;
                row_select <= {row_select[2:0], row_select[3]};
              end else begin
                db_cnt <= db_cnt + CNT_W'(1);
              end
            end else begin
              db_cnt <= '0;
            end
          end
          default: begin
            db_cnt <= '0;
            state  <= SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed bench for keypad_entry with a behavioural keypad
// model (up to two pressed keys) driving col_in from row_select.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_in;
  logic        clear;
  logic [3:0]  row_select;
  logic [15:0] value;
  logic [3:0]  key_code;
  logic        key_valid;

  logic       p_en, p2_en;
  logic [1:0] p_r, p_c, p2_r, p2_c;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          do_clear;
    logic [1:0]  r;
    logic [1:0]  c;
    logic [3:0]  code;
    logic [15:0] val;
  } vec_t;

  vec_t vecs [6];

  keypad_entry #(
    .CLOCK_SPEED    (40),
    .SCAN_HZ        (10),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_in     (col_in),
    .clear      (clear),
    .row_select (row_select),
    .value      (value),
    .key_code   (key_code),
    .key_valid  (key_valid)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    if (p_en && !row_select[p_r]) col_in[p_c] = 1'b0;
    if (p2_en && !row_select[p2_r]) col_in[p2_c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cycles(input int n, output int pulses, output int changes);
    logic [3:0] prev;
    pulses  = 0;
    changes = 0;
    prev    = row_select;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (row_select != prev) changes++;
      prev = row_select;
    end
  endtask

  task automatic wait_kv(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (key_valid) ok = 1'b1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    check("clear_value", 32'(value), 32'h0);
  endtask

  // Hold the key through acceptance and beyond, then release it fully.
  task automatic press_key(input string name, input logic [1:0] r, input logic [1:0] c,
                           input logic [3:0] code, input logic [15:0] val);
    bit ok;
    int pulses, changes, extra;
    logic [3:0] held_row;
    held_row = 4'hF;
    held_row[r] = 1'b0;
    p_r = r; p_c = c; p_en = 1'b1;
    wait_kv(80, ok);
    check({name, "_kv_seen"}, 32'(ok), 32'h1);
    if (ok) begin
      check({name, "_code"}, 32'(key_code), 32'(code));
      check({name, "_value"}, 32'(value), 32'(val));
    end
    run_cycles(30, pulses, changes);
    extra = pulses;
    check({name, "_row_frozen"}, 32'(row_select), 32'(held_row));
    p_en = 1'b0;
    run_cycles(30, pulses, changes);
    extra += pulses;
    check({name, "_single_kv"}, 32'(extra), 32'h0);
  endtask

  initial begin
    bit ok;
    int pulses, changes, last_change, nchg, kv_seen;
    logic [3:0] prev;

    vecs[0] = '{1'b0, 2'd2, 2'd1, 4'h8, 16'h0008};
    vecs[1] = '{1'b1, 2'd0, 2'd0, 4'h1, 16'h0001};
    vecs[2] = '{1'b0, 2'd0, 2'd1, 4'h2, 16'h0012};
    vecs[3] = '{1'b0, 2'd0, 2'd2, 4'h3, 16'h0123};
    vecs[4] = '{1'b0, 2'd0, 2'd3, 4'hA, 16'h123A};
    vecs[5] = '{1'b0, 2'd1, 2'd1, 4'h5, 16'h23A5};

    rst = 1'b1; clear = 1'b0;
    p_en = 1'b0; p2_en = 1'b0;
    p_r = 2'd0; p_c = 2'd0; p2_r = 2'd0; p2_c = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state, then free scanning with no key.
    check("rst_row", 32'(row_select), 32'hE);
    check("rst_value", 32'(value), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_kv", 32'(key_valid), 32'h0);
    prev = row_select; last_change = -1; nchg = 0; kv_seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (key_valid) kv_seen++;
      if (row_select != prev) begin
        check("row_rotate", 32'(row_select), 32'({prev[2:0], prev[3]}));
        if (last_change >= 0) check("row_period", 32'(i - last_change), 32'd4);
        last_change = i;
        nchg++;
      end
      prev = row_select;
    end
    check("row_changes", 32'(nchg >= 5), 32'h1);
    check("idle_kv", 32'(kv_seen), 32'h0);
    check("idle_value", 32'(value), 32'h0);

    // Single press, then the 1,2,3,A,5 walk with wrap.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_clear) pulse_clear();
      press_key($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].code, vecs[i].val);
    end

    // Bouncing key 8: no acceptance while toggling, one once stable.
    p_r = 2'd2; p_c = 2'd1;
    kv_seen = 0;
    for (int k = 0; k < 6; k++) begin
      p_en = (k % 2 == 0);
      run_cycles(5, pulses, changes);
      kv_seen += pulses;
    end
    check("bounce_no_kv", 32'(kv_seen), 32'h0);
    press_key("bounce", 2'd2, 2'd1, 4'h8, 16'h3A58);

    // Two keys in one row: no key, scanning continues.
    p_r = 2'd1; p_c = 2'd0; p_en = 1'b1;
    p2_r = 2'd1; p2_c = 2'd2; p2_en = 1'b1;
    run_cycles(60, pulses, changes);
    check("twokey_no_kv", 32'(pulses), 32'h0);
    check("twokey_scanning", 32'(changes >= 10), 32'h1);
    p_en = 1'b0; p2_en = 1'b0;
    run_cycles(20, pulses, changes);

    // Build 0x1234, then clear in the key_valid cycle of key 7.
    pulse_clear();
    press_key("k1", 2'd0, 2'd0, 4'h1, 16'h0001);
    press_key("k2", 2'd0, 2'd1, 4'h2, 16'h0012);
    press_key("k3", 2'd0, 2'd2, 4'h3, 16'h0123);
    press_key("k4", 2'd1, 2'd0, 4'h4, 16'h1234);
    p_r = 2'd2; p_c = 2'd0; p_en = 1'b1;
    wait_kv(80, ok);
    check("k7_kv_seen", 32'(ok), 32'h1);
    if (ok) begin
      check("k7_code", 32'(key_code), 32'h7);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("k7_clear_value", 32'(value), 32'h0007);
      check("k7_clear_code", 32'(key_code), 32'h7);
    end
    p_en = 1'b0;
    run_cycles(30, pulses, changes);

    // Async reset while HELD; the still-held key is accepted once afterwards.
    p_r = 2'd2; p_c = 2'd1; p_en = 1'b1;
    wait_kv(80, ok);
    check("hold_kv_seen", 32'(ok), 32'h1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_row", 32'(row_select), 32'hE);
    check("async_value", 32'(value), 32'h0);
    check("async_code", 32'(key_code), 32'h0);
    check("async_kv", 32'(key_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    press_key("redetect", 2'd2, 2'd1, 4'h8, 16'h0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
